ctr_step_sequencer: RTL and testbench



---
 rtl/ctr_seq_pkg.sv | 23 ++
 rtl/cmd_fifo.sv | 57 +++++
 rtl/ctr_step_sequencer.sv | 150 +++++++++++++++
 tb/tb_ctr_step_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_seq_pkg.sv
// Shared types for the counter step sequencer: FSM states, direction codes
// and the queued command layout.
package ctr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int CMD_STEP_W = 5;

  typedef struct packed {
    logic                  dir;
    logic [CMD_STEP_W-1:0] steps;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Shallow synchronous command FIFO with flush and occupancy level.
// The head entry is read asynchronously so a pop can latch it on the same edge.
module cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    level_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (level_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (PTR_W+1)'(1);
        2'b01:   level_reg <= level_reg - (PTR_W+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/ctr_step_sequencer.sv
// Drives a 5-bit up/down counter's ct/cn inputs from queued (dir, steps)
// commands, keeping a shadow of the value the counter should hold.
module ctr_step_sequencer
  import ctr_seq_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STEP_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_dir,
  input  logic [STEP_W-1:0]      cmd_steps,
  input  logic                   start,
  input  logic                   abort,
  output logic                   ct,
  output logic                   cn,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       shadow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  state_t             state_reg;
  logic [STEP_W-1:0]  rem_reg;
  logic               ct_reg;
  logic               cn_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   shadow_reg;
  logic [WIDTH-1:0]   shadow_next;

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               load_cmd;
  logic [STEP_W:0]    head_data;

  // A command is popped on the edge that enters SETUP, so ct is already
  // valid for the whole SETUP cycle.
  always_comb begin
    load_cmd = 1'b0;
    if (!abort) begin
      case (state_reg)
        ST_IDLE: load_cmd = start && !fifo_empty;
        ST_HOLD: load_cmd = !fifo_empty;
        default: load_cmd = 1'b0;
      endcase
    end
  end

  assign push        = cmd_valid && cmd_ready && !abort;
  assign cmd_ready   = !fifo_full;
  assign shadow_next = (ct_reg == DIR_DN) ? shadow_reg - WIDTH'(1)
                                          : shadow_reg + WIDTH'(1);

  cmd_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (STEP_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({cmd_dir, cmd_steps}),
    .pop     (load_cmd),
    .flush   (abort),
    .rd_data (head_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      rem_reg    <= '0;
      ct_reg     <= 1'b0;
      cn_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      shadow_reg <= '0;
    end else if (abort) begin
      // ct and shadow deliberately keep their values
      state_reg <= ST_IDLE;
      cn_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (load_cmd) begin
            state_reg <= ST_SETUP;
            busy_reg  <= 1'b1;
            ct_reg    <= head_data[STEP_W];
            rem_reg   <= head_data[STEP_W-1:0];
          end
        end
        ST_SETUP: begin
          if (rem_reg != '0) begin
            state_reg  <= ST_HIGH;
            cn_reg     <= 1'b1;
            shadow_reg <= shadow_next;
          end else begin
            state_reg <= ST_HOLD;
          end
        end
        ST_HIGH: begin
          state_reg <= ST_LOW;
          cn_reg    <= 1'b0;
          rem_reg   <= rem_reg - STEP_W'(1);
        end
        ST_LOW: begin
          if (rem_reg != '0) begin
            state_reg  <= ST_HIGH;
            cn_reg     <= 1'b1;
            shadow_reg <= shadow_next;
          end else begin
            state_reg <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (load_cmd) begin
            state_reg <= ST_SETUP;
            ct_reg    <= head_data[STEP_W];
            rem_reg   <= head_data[STEP_W-1:0];
          end else begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cn_reg    <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign ct     = ct_reg;
  assign cn     = cn_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign shadow = shadow_reg;

endmodule

// File: tb/tb_ctr_step_sequencer.sv
// Scoreboard bench: expected pulse groups and done events are queued by the
// stimulus and checked by an independent monitor watching ct/cn/done.
module tb_ctr_step_sequencer;
  import ctr_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [4:0] cmd_steps = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ct, cn, busy, done;
  logic [4:0] shadow;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int pulse_total = 0;

  typedef struct { logic dir; int cnt; int sh; } grp_t;
  typedef struct { int sh; int lat; } done_t;
  grp_t  grp_q[$];
  done_t done_q[$];

  ctr_step_sequencer #(.WIDTH(5), .STEP_W(5), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .start      (start),
    .abort      (abort),
    .ct         (ct),
    .cn         (cn),
    .busy       (busy),
    .done       (done),
    .shadow     (shadow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the 5-bit counter: steps on each rising edge of cn.
  logic [4:0] model_cnt;
  logic       cn_q;
  always @(posedge clk) begin
    if (rst) begin
      model_cnt <= '0;
      cn_q      <= 1'b0;
    end else begin
      if (cn && !cn_q) model_cnt <= ct ? model_cnt - 5'd1 : model_cnt + 5'd1;
      cn_q <= cn;
    end
  end

  // Monitor: a pulse group ends after two consecutive low cycles of cn.
  int   grp_cnt = 0;
  int   low_run = 0;
  logic grp_dir = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      grp_cnt = 0;
      low_run = 0;
    end else begin
      if (cn) begin
        if (grp_cnt == 0) grp_dir = ct;
        grp_cnt++;
        pulse_total++;
        low_run = 0;
      end else begin
        low_run++;
        if (low_run == 2 && grp_cnt != 0) begin
          checks++;
          if (grp_q.size() == 0) begin
            errors++;
            $display("FAIL grp_unexpected: got %0d pulses, no group expected", grp_cnt);
          end else begin
            grp_t e;
            e = grp_q.pop_front();
            if (grp_cnt != e.cnt || grp_dir != e.dir || int'(shadow) != e.sh
                || model_cnt != shadow) begin
              errors++;
              $display("FAIL grp: pulses %0d dir %0d shadow %0d counter %0d, required pulses %0d dir %0d shadow %0d",
                       grp_cnt, grp_dir, shadow, model_cnt, e.cnt, e.dir, e.sh);
            end else begin
              $display("grp ok: pulses %0d dir %0d shadow %0d", grp_cnt, grp_dir, shadow);
            end
          end
          grp_cnt = 0;
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done at cycle %0d with nothing expected", cyc - start_cyc);
        end else begin
          done_t d;
          d = done_q.pop_front();
          if (int'(shadow) != d.sh || (cyc - start_cyc) != d.lat || busy
              || model_cnt != shadow) begin
            errors++;
            $display("FAIL done: shadow %0d cycle %0d busy %0d counter %0d, required shadow %0d cycle %0d busy 0",
                     shadow, cyc - start_cyc, busy, model_cnt, d.sh, d.lat);
          end else begin
            $display("done ok: shadow %0d at cycle %0d", shadow, cyc - start_cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("chk ok: %s = %0d", name, act);
    end
  endtask

  task automatic push_cmd(input cmd_t c);
    int   guard;
    logic acc;
    guard = 0;
    cmd_valid = 1'b1;
    cmd_dir   = c.dir;
    cmd_steps = c.steps;
    do begin
      acc = cmd_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    cmd_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready 0, required 1");
    end
  endtask

  task automatic exp_grp(input logic dir, input int cnt, input int sh);
    grp_t g;
    g.dir = dir; g.cnt = cnt; g.sh = sh;
    grp_q.push_back(g);
  endtask

  task automatic go(input int sh, input int lat);
    done_t d;
    d.sh = sh; d.lat = lat;
    done_q.push_back(d);
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == d0; i++) tick();
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, required done", limit);
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ct"}, ct, 0);
    chk({tag, "_cn"}, cn, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_shadow"}, shadow, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
  endtask

  initial begin
    int p0;
    // Reset values
    tick();
    tick();
    chk_reset_state("rst");
    rst = 1'b0;

    // +4 -2 +8 -6: 48 sequence cycles, done in cycle 49
    push_cmd('{1'b0, 5'd4});
    push_cmd('{1'b1, 5'd2});
    push_cmd('{1'b0, 5'd8});
    push_cmd('{1'b1, 5'd6});
    chk("seq_full_ready", cmd_ready, 0);
    chk("seq_level", fifo_level, 4);
    exp_grp(1'b0, 4, 4);
    exp_grp(1'b1, 2, 2);
    exp_grp(1'b0, 8, 10);
    exp_grp(1'b1, 6, 4);
    go(4, 49);
    chk("seq_busy", busy, 1);
    wait_done(80);

    // Wrap: 0-1 = 31, 31-1 = 30, 30+3 = 1
    do_reset();
    push_cmd('{1'b1, 5'd1});
    exp_grp(1'b1, 1, 31);
    go(31, 5);
    wait_done(20);
    push_cmd('{1'b1, 5'd1});
    exp_grp(1'b1, 1, 30);
    go(30, 5);
    wait_done(20);
    push_cmd('{1'b0, 5'd3});
    exp_grp(1'b0, 3, 1);
    go(1, 9);
    wait_done(20);

    // Zero-step command between +2 and +1: 12 cycles, shadow 3
    do_reset();
    push_cmd('{1'b0, 5'd2});
    push_cmd('{1'b1, 5'd0});
    push_cmd('{1'b0, 5'd1});
    exp_grp(1'b0, 2, 2);
    exp_grp(1'b0, 1, 3);
    go(3, 13);
    wait_done(30);

    // Full FIFO: fifth push held until the first pop
    do_reset();
    for (int i = 0; i < 4; i++) push_cmd('{1'b0, 5'd1});
    chk("full_ready", cmd_ready, 0);
    for (int i = 1; i <= 4; i++) exp_grp(1'b0, 1, i);
    exp_grp(1'b0, 2, 6);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_steps = 5'd2;
    go(6, 23);
    chk("full_ready_after_pop", cmd_ready, 1);
    chk("full_level_after_pop", fifo_level, 3);
    tick();
    cmd_valid = 1'b0;
    chk("full_level_after_push", fifo_level, 4);
    wait_done(40);

    // Abort during +8 after the third HIGH, with a same-cycle push
    do_reset();
    push_cmd('{1'b0, 5'd8});
    push_cmd('{1'b1, 5'd2});
    exp_grp(1'b0, 3, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_steps = 5'd5;
    tick();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_shadow", shadow, 3);
    chk("abort_level", fifo_level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cn", cn, 0);
    chk("abort_ct", ct, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_level_later", fifo_level, 0);
    p0 = pulse_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_empty_start_busy", busy, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_empty_start_pulses", pulse_total - p0, 0);

    // Reset mid-sequence
    do_reset();
    push_cmd('{1'b1, 5'd5});
    push_cmd('{1'b0, 5'd3});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk_reset_state("midrst");
    rst = 1'b0;
    p0 = pulse_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("midrst_start_busy", busy, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("midrst_start_pulses", pulse_total - p0, 0);
    chk("midrst_level", fifo_level, 0);

    tick();
    tick();
    chk("left_groups", grp_q.size(), 0);
    chk("left_dones", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
